// File: rtl/fdc_drive_mux.sv
// Floppy-controller front end: $FF40 control register, drive/side decode, controller
// clock enable, motor timeout and a CPU-to-controller access stretcher for NUM_DRIVES drives.
module fdc_drive_mux #(
    parameter int          NUM_DRIVES  = 4,
    parameter int          CE_DIV      = 7,
    parameter logic [23:0] MOTOR_TICKS = 24'd2000000
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [1:0]              ADDRESS,
    input  logic [7:0]              DATA_IN,
    input  logic                    CTRL_WR,
    input  logic                    CTRL_RD,
    input  logic                    FDC_RD_REQ,
    input  logic                    FDC_WR_REQ,
    output logic [7:0]              DATA_OUT,
    output logic                    CE,
    output logic [NUM_DRIVES-1:0]   DRV_RD,
    output logic [NUM_DRIVES-1:0]   DRV_WR,
    output logic [1:0]              DRV_ADDR,
    output logic [7:0]              DRV_DIN,
    input  logic [8*NUM_DRIVES-1:0] DRV_DOUT,
    input  logic [NUM_DRIVES-1:0]   DRV_DRQ,
    input  logic [NUM_DRIVES-1:0]   DRV_INTRQ,
    output logic                    SIDE,
    output logic                    MOTOR_ON,
    output logic                    HALT,
    output logic                    NMI,
    output logic                    FIRQ
);

    localparam int            CW      = $clog2(CE_DIV);
    localparam logic [CW-1:0] CE_LAST = CW'(CE_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_CLEAR} state_t;

    logic [CW-1:0] ce_cnt;
    logic [7:0]    ctrl;
    logic [1:0]    idx, tgt;
    logic [23:0]   timer;
    state_t        state;
    logic          acc_wr, ce_seen;
    logic          rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3;
    logic          rd_rise, wr_rise, accept;
    logic          dec_upd, dec_side;
    logic [1:0]    dec_idx;
    logic          sel_drq, sel_intrq;
    logic [7:0]    sel_dout;

    assign CE = (ce_cnt == CE_LAST);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)  ce_cnt <= '0;
        else if (CE)   ce_cnt <= '0;
        else           ce_cnt <= ce_cnt + CW'(1);
    end

    // s3 only remembers the previous s2 for edge detection
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            {rd_s1, rd_s2, rd_s3} <= '0;
            {wr_s1, wr_s2, wr_s3} <= '0;
        end else begin
            {rd_s1, rd_s2, rd_s3} <= {FDC_RD_REQ, rd_s1, rd_s2};
            {wr_s1, wr_s2, wr_s3} <= {FDC_WR_REQ, wr_s1, wr_s2};
        end
    end

    assign rd_rise = rd_s2 & ~rd_s3;
    assign wr_rise = wr_s2 & ~wr_s3;
    assign accept  = (state == S_IDLE) & (rd_rise | wr_rise);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DRV_ADDR <= '0;
            DRV_DIN  <= '0;
        end else if ((rd_s1 & ~rd_s2) | (wr_s1 & ~wr_s2)) begin
            DRV_ADDR <= ADDRESS;
            DRV_DIN  <= DATA_IN;
        end
    end

    always_comb begin
        dec_upd  = 1'b1;
        dec_idx  = 2'd0;
        dec_side = DATA_IN[6];
        case (DATA_IN[2:0])
            3'b001: dec_idx = 2'd0;
            3'b010: dec_idx = 2'd1;
            3'b100: dec_idx = 2'd2;
            3'b000: begin
                dec_idx  = 2'd3;
                dec_side = 1'b0;
                dec_upd  = DATA_IN[6];
            end
            default: dec_upd = 1'b0;
        endcase
    end

    // An index beyond NUM_DRIVES matches no slot and reads as an idle, empty drive
    always_comb begin
        sel_drq   = 1'b0;
        sel_intrq = 1'b0;
        sel_dout  = 8'hFF;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (int'(idx) == i) begin
                sel_drq   = DRV_DRQ[i];
                sel_intrq = DRV_INTRQ[i];
                sel_dout  = DRV_DOUT[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl  <= '0;
            idx   <= '0;
            SIDE  <= 1'b0;
            timer <= '0;
        end else begin
            if (CTRL_WR) begin
                ctrl[6:0] <= DATA_IN[6:0];
                if (dec_upd) begin
                    idx  <= dec_idx;
                    SIDE <= dec_side;
                end
            end
            if (sel_intrq)    ctrl[7] <= 1'b0;
            else if (CTRL_WR) ctrl[7] <= DATA_IN[7];
            // Timer 1->0 on a CE is the timeout; MOTOR_TICKS of 0 never starts it
            if (CTRL_WR)
                timer <= DATA_IN[3] ? MOTOR_TICKS : '0;
            else if (accept && ctrl[3])
                timer <= MOTOR_TICKS;
            else if (CE && timer != '0) begin
                timer <= timer - 24'd1;
                if (timer == 24'd1) ctrl[3] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            acc_wr  <= 1'b0;
            tgt     <= '0;
            ce_seen <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (wr_rise | rd_rise) begin
                    acc_wr  <= wr_rise;
                    tgt     <= idx;
                    ce_seen <= 1'b0;
                    state   <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (ce_seen) state   <= S_CLEAR;
                    else if (CE) ce_seen <= 1'b1;
                end
                S_CLEAR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pending write masks the read level so a colliding read never strobes
    for (genvar g = 0; g < NUM_DRIVES; g++) begin : g_drv
        assign DRV_WR[g] = (state == S_ACTIVE) & acc_wr & (int'(tgt) == g);
        assign DRV_RD[g] = ((state == S_IDLE) & rd_s2 & ~wr_s2 & (int'(idx) == g)) |
                           ((state == S_ACTIVE) & ~acc_wr & (int'(tgt) == g));
    end

    assign DATA_OUT = CTRL_RD ? ctrl : sel_dout;
    assign MOTOR_ON = ctrl[3];
    assign HALT     = ctrl[7] & ~sel_drq;
    assign FIRQ     = sel_drq;
    assign NMI      = ctrl[5] & sel_intrq;

endmodule

// File: tb/tb_fdc_drive_mux.sv
// Directed bench for fdc_drive_mux: a 4-drive/CE_DIV=7 instance and a 2-drive/CE_DIV=2
// instance with a 10-tick motor timeout share one stimulus stream.
module tb_fdc_drive_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  address;
    logic [7:0]  data_in;
    logic        ctrl_wr, ctrl_rd, rd_req, wr_req;
    logic [31:0] dout;
    logic [3:0]  drq, intrq;

    logic [7:0] a_data, a_din, b_data, b_din;
    logic [3:0] a_rd, a_wr;
    logic [1:0] b_rd, b_wr, a_addr, b_addr;
    logic       a_ce, a_side, a_motor, a_halt, a_nmi, a_firq;
    logic       b_ce, b_side, b_motor, b_halt, b_nmi, b_firq;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fdc_drive_mux #(.NUM_DRIVES(4), .CE_DIV(7)) u_a (
        .CLK(clk), .RESET_N(rst_n), .ADDRESS(address), .DATA_IN(data_in),
        .CTRL_WR(ctrl_wr), .CTRL_RD(ctrl_rd), .FDC_RD_REQ(rd_req), .FDC_WR_REQ(wr_req),
        .DATA_OUT(a_data), .CE(a_ce), .DRV_RD(a_rd), .DRV_WR(a_wr),
        .DRV_ADDR(a_addr), .DRV_DIN(a_din), .DRV_DOUT(dout), .DRV_DRQ(drq),
        .DRV_INTRQ(intrq), .SIDE(a_side), .MOTOR_ON(a_motor), .HALT(a_halt),
        .NMI(a_nmi), .FIRQ(a_firq)
    );

    fdc_drive_mux #(.NUM_DRIVES(2), .CE_DIV(2), .MOTOR_TICKS(24'd10)) u_b (
        .CLK(clk), .RESET_N(rst_n), .ADDRESS(address), .DATA_IN(data_in),
        .CTRL_WR(ctrl_wr), .CTRL_RD(ctrl_rd), .FDC_RD_REQ(rd_req), .FDC_WR_REQ(wr_req),
        .DATA_OUT(b_data), .CE(b_ce), .DRV_RD(b_rd), .DRV_WR(b_wr),
        .DRV_ADDR(b_addr), .DRV_DIN(b_din), .DRV_DOUT(dout[15:0]), .DRV_DRQ(drq[1:0]),
        .DRV_INTRQ(intrq[1:0]), .SIDE(b_side), .MOTOR_ON(b_motor), .HALT(b_halt),
        .NMI(b_nmi), .FIRQ(b_firq)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] a_out;
        logic [7:0] b_out;
        logic       side;
        logic       motor;
        logic       halt;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ctrl_write(input logic [7:0] v);
        @(negedge clk);
        data_in = v;
        ctrl_wr = 1'b1;
        @(negedge clk);
        ctrl_wr = 1'b0;
    endtask

    initial begin
        int n, w, bad, seen;

        tbl[0] = '{8'h41, 8'hD0, 8'hD0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h40, 8'hD3, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{8'h03, 8'hD3, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{8'h02, 8'hD1, 8'hD1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'hD1, 8'hD1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h44, 8'hD2, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'h47, 8'hD2, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{8'h09, 8'hD0, 8'hD0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{8'h22, 8'hD1, 8'hD1, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{8'h81, 8'hD0, 8'hD0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; address = '0; data_in = '0; ctrl_wr = 1'b0; ctrl_rd = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; dout = 32'hD3D2D1D0; drq = 4'b0001; intrq = '0;

        // reset state
        cyc(3);
        check("rst_ce", 32'(a_ce), 0);
        check("rst_wr", 32'(a_wr), 0);
        check("rst_rd", 32'(a_rd), 0);
        check("rst_motor", 32'(a_motor), 0);
        check("rst_side", 32'(a_side), 0);
        check("rst_addr", 32'(a_addr), 0);
        check("rst_din", 32'(a_din), 0);
        check("rst_halt", 32'(a_halt), 0);
        check("rst_nmi", 32'(a_nmi), 0);
        check("rst_firq", 32'(a_firq), 1);
        ctrl_rd = 1'b1; #1;
        check("rst_ctrl", 32'(a_data), 0);
        ctrl_rd = 1'b0; drq = '0;
        @(negedge clk) rst_n = 1'b1;
        cyc(2);

        // control register decode table
        for (int i = 0; i < 10; i++) begin
            ctrl_write(tbl[i].din);
            check($sformatf("tbl%0d_a_data", i), 32'(a_data), 32'(tbl[i].a_out));
            check($sformatf("tbl%0d_b_data", i), 32'(b_data), 32'(tbl[i].b_out));
            check($sformatf("tbl%0d_side", i), 32'(a_side), 32'(tbl[i].side));
            check($sformatf("tbl%0d_b_side", i), 32'(b_side), 32'(tbl[i].side));
            check($sformatf("tbl%0d_motor", i), 32'(a_motor), 32'(tbl[i].motor));
            check($sformatf("tbl%0d_halt", i), 32'(a_halt), 32'(tbl[i].halt));
            ctrl_rd = 1'b1; #1;
            check($sformatf("tbl%0d_readback", i), 32'(a_data), 32'(tbl[i].din));
            ctrl_rd = 1'b0;
        end

        // halt_en / HALT / FIRQ / NMI
        ctrl_write(8'h8A);
        check("halt_set", 32'(a_halt), 1);
        check("halt_motor", 32'(a_motor), 1);
        check("halt_firq0", 32'(a_firq), 0);
        drq[1] = 1'b1; #1;
        check("drq_halt", 32'(a_halt), 0);
        check("drq_firq", 32'(a_firq), 1);
        drq[1] = 1'b0; #1;
        check("drq_off_halt", 32'(a_halt), 1);
        intrq[1] = 1'b1; #1;
        check("intrq_halt_same_clk", 32'(a_halt), 1);
        check("intrq_nmi_nodensity", 32'(a_nmi), 0);
        @(negedge clk);
        check("intrq_halt_cleared", 32'(a_halt), 0);
        ctrl_write(8'h8A);
        ctrl_rd = 1'b1; #1;
        check("halt_wr_during_intrq", 32'(a_data), 'h0A);
        ctrl_rd = 1'b0;
        ctrl_write(8'h22);
        check("nmi_density", 32'(a_nmi), 1);
        intrq = '0; #1;
        check("nmi_off", 32'(a_nmi), 0);

        // CE period and width
        n = 0;
        while (a_ce !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("ce_found", 32'(n < 20), 1);
        @(negedge clk);
        check("ce_width", 32'(a_ce), 0);
        w = 1;
        while (a_ce !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        check("ce_period", w, 7);

        // write strobe
        ctrl_write(8'h01);
        address = 2'd3; data_in = 8'h5A; wr_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (a_wr == '0 && n < 10);
        check("wr_latency", n, 3);
        check("wr_target", 32'(a_wr), 'b0001);
        check("wr_addr", 32'(a_addr), 3);
        check("wr_din", 32'(a_din), 'h5A);
        w = 1;
        while (a_wr != '0 && w < 20) begin @(negedge clk); w++; end
        check("wr_width_2_to_8", 32'(w >= 2 && w <= 8), 1);
        wr_req = 1'b0;
        cyc(4);

        // read to absent drive on the 2-drive instance
        ctrl_write(8'h40);
        rd_req = 1'b1; bad = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (b_rd != '0) bad++;
            if (k == 4) check("rd_idx3_a", 32'(a_rd), 'b1000);
        end
        check("rd_absent_no_strobe", bad, 0);
        check("rd_absent_data", 32'(b_data), 'hFF);
        rd_req = 1'b0;
        cyc(4);

        // read/write collision
        ctrl_write(8'h01);
        rd_req = 1'b1; wr_req = 1'b1; bad = 0; seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (a_rd != '0) bad++;
            if (a_wr == 4'b0001) seen = 1;
        end
        check("collide_no_rd", bad, 0);
        check("collide_wr_seen", seen, 1);
        rd_req = 1'b0; wr_req = 1'b0;
        cyc(10);

        // reset during ACTIVE
        ctrl_write(8'h01);
        wr_req = 1'b1; n = 0;
        while (a_wr == '0 && n < 10) begin @(negedge clk); n++; end
        check("midrst_wr_up", 32'(a_wr), 'b0001);
        rst_n = 1'b0; #1;
        check("midrst_wr_drop", 32'(a_wr), 0);
        check("midrst_rd_drop", 32'(a_rd), 0);
        wr_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        cyc(6);
        check("midrst_discarded", 32'(a_wr), 0);

        // motor timeout: 10 ticks of CE_DIV=2 -> drop 20 CLK after the write edge
        n = 0;
        while (b_ce !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        data_in = 8'h08; ctrl_wr = 1'b1;
        @(negedge clk) ctrl_wr = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1)  check("motor_on", 32'(b_motor), 1);
            if (k == 20) check("motor_still_on_20", 32'(b_motor), 1);
            if (k == 21) check("motor_off_21", 32'(b_motor), 0);
        end
        cyc(3);

        // access at tick 5 reloads the timer: drop moves out by 5 ticks
        n = 0;
        while (b_ce !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        data_in = 8'h08; ctrl_wr = 1'b1;
        @(negedge clk) ctrl_wr = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 9)  wr_req = 1'b1;
            if (k == 14) wr_req = 1'b0;
            if (k == 21) check("motor_reload_on_21", 32'(b_motor), 1);
            if (k == 30) check("motor_reload_on_30", 32'(b_motor), 1);
            if (k == 31) check("motor_reload_off_31", 32'(b_motor), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
